// File: rtl/sample_loader.sv
//==============================================================================
// Module      : sample_loader
// Description : Loads one 16-point complex frame into the FFT input buffer in
//               natural or bit-reversed order, zero-padding short frames.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sample_loader #(
  parameter int N     = 16,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_xr,
  input  logic signed [WIDTH-1:0] s_xi,
  input  logic                    s_last,
  input  logic                    bitrev_en,
  input  logic                    fft_done,
  output logic                    load,
  output logic [3:0]              addr_in,
  output logic signed [WIDTH-1:0] xr_in,
  output logic signed [WIDTH-1:0] xi_in,
  output logic                    frame_ready,
  output logic                    busy,
  output logic                    err_short,
  output logic                    err_long
);

  localparam logic [3:0] C_LAST = 4'(N - 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic                    r_brev;
  logic                    r_load;
  logic [3:0]              r_addr;
  logic signed [WIDTH-1:0] r_xr;
  logic signed [WIDTH-1:0] r_xi;
  logic                    r_last_wr;
  logic                    r_frame_ready;
  logic                    r_err_short;
  logic                    r_err_long;

  logic w_beat;
  logic w_cnt_last;
  logic w_brev_cur;

  function automatic logic [3:0] f_map(input logic [3:0] c, input logic rev);
    return rev ? {c[0], c[1], c[2], c[3]} : c;
  endfunction

  assign s_ready    = (r_state == ST_FILL) && !rst;
  assign busy       = (r_state != ST_FILL) && !rst;
  assign w_beat     = s_valid && s_ready;
  assign w_cnt_last = (r_cnt == C_LAST);
  // The first beat of a frame uses the live bitrev_en; later beats use the latched copy.
  assign w_brev_cur = (r_cnt == 4'd0) ? bitrev_en : r_brev;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_beat) begin
          if (w_cnt_last)  w_state_nxt = ST_HOLD;
          else if (s_last) w_state_nxt = ST_PAD;
        end
      end
      ST_PAD:  if (w_cnt_last) w_state_nxt = ST_HOLD;
      ST_HOLD: if (fft_done)   w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= 4'd0;
      r_brev        <= 1'b0;
      r_load        <= 1'b0;
      r_addr        <= 4'd0;
      r_xr          <= '0;
      r_xi          <= '0;
      r_last_wr     <= 1'b0;
      r_frame_ready <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
    end else begin
      r_load        <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_last_wr     <= 1'b0;
      r_frame_ready <= r_last_wr;
      case (r_state)
        ST_FILL: begin
          if (w_beat) begin
            r_load <= 1'b1;
            r_addr <= f_map(r_cnt, w_brev_cur);
            r_xr   <= s_xr;
            r_xi   <= s_xi;
            if (r_cnt == 4'd0) r_brev <= bitrev_en;
            if (w_cnt_last) begin
              r_err_long <= !s_last;
              r_last_wr  <= 1'b1;
              r_cnt      <= 4'd0;
            end else begin
              r_err_short <= s_last;
              r_cnt       <= r_cnt + 4'd1;
            end
          end
        end
        ST_PAD: begin
          r_load <= 1'b1;
          r_addr <= f_map(r_cnt, r_brev);
          r_xr   <= '0;
          r_xi   <= '0;
          if (w_cnt_last) begin
            r_last_wr <= 1'b1;
            r_cnt     <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_HOLD: if (fft_done) r_cnt <= 4'd0;
        default: r_cnt <= 4'd0;
      endcase
    end
  end

  assign load        = r_load;
  assign addr_in     = r_addr;
  assign xr_in       = r_xr;
  assign xi_in       = r_xi;
  assign frame_ready = r_frame_ready;
  assign err_short   = r_err_short;
  assign err_long    = r_err_long;

endmodule

`default_nettype wire

// File: tb/tb_sample_loader.sv
//==============================================================================
// Module      : tb_sample_loader
// Description : Randomized self-checking bench for sample_loader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sample_loader;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic signed [W-1:0] s_xr = '0;
  logic signed [W-1:0] s_xi = '0;
  logic                s_last = 1'b0;
  logic                bitrev_en = 1'b0;
  logic                fft_done = 1'b0;
  logic                load;
  logic [3:0]          addr_in;
  logic signed [W-1:0] xr_in;
  logic signed [W-1:0] xi_in;
  logic                frame_ready;
  logic                busy;
  logic                err_short;
  logic                err_long;

  sample_loader #(.N(16), .WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_xr(s_xr), .s_xi(s_xi), .s_last(s_last), .bitrev_en(bitrev_en),
    .fft_done(fft_done), .load(load), .addr_in(addr_in), .xr_in(xr_in),
    .xi_in(xi_in), .frame_ready(frame_ready), .busy(busy),
    .err_short(err_short), .err_long(err_long)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  int                  beat_cyc[$];
  logic [3:0]          wr_addr[$];
  logic signed [W-1:0] wr_xr[$];
  logic signed [W-1:0] wr_xi[$];
  int                  wr_cyc[$];
  bit                  wr_busy[$];
  int fr_n, fr_cyc, es_n, es_cyc, el_n, el_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rev4(input int i);
    return (i % 2) * 8 + ((i / 2) % 2) * 4 + ((i / 4) % 2) * 2 + (i / 8) % 2;
  endfunction

  task automatic clear_obs();
    beat_cyc.delete(); wr_addr.delete(); wr_xr.delete(); wr_xi.delete();
    wr_cyc.delete(); wr_busy.delete();
    fr_n = 0; fr_cyc = 0; es_n = 0; es_cyc = 0; el_n = 0; el_cyc = 0;
  endtask

  // One clock: note acceptance before the edge, observe registered outputs after it.
  task automatic step();
    bit beat;
    #1;
    beat = s_valid && s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (beat) beat_cyc.push_back(cyc);
    if (load) begin
      wr_addr.push_back(addr_in); wr_xr.push_back(xr_in); wr_xi.push_back(xi_in);
      wr_cyc.push_back(cyc); wr_busy.push_back(busy);
    end
    if (frame_ready) begin fr_n++; fr_cyc = cyc; end
    if (err_short)   begin es_n++; es_cyc = cyc; end
    if (err_long)    begin el_n++; el_cyc = cyc; end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_load"}, load, 0);
    check({tag, "_addr"}, addr_in, 0);
    check({tag, "_xr"}, xr_in, 0);
    check({tag, "_xi"}, xi_in, 0);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_short"}, err_short, 0);
    check({tag, "_err_long"}, err_long, 0);
  endtask

  // Sends n beats, then checks the whole frame as a transaction against the model.
  task automatic run_frame(input int n, input bit give_last, input bit brev,
                           input int vprob, input bit inj);
    logic signed [W-1:0] ex_xr[16];
    logic signed [W-1:0] ex_xi[16];
    int sent, guard, nb, bad_lat, bad_pad, bad_busy, ea;
    logic signed [W-1:0] exr, exi;
    clear_obs();
    sent = 0; guard = 0;
    while (sent < n && guard < 500) begin
      guard++;
      s_valid   = ($urandom_range(99) < vprob);
      s_xr      = W'($urandom);
      s_xi      = W'($urandom);
      s_last    = s_valid ? (give_last && sent == n - 1) : 1'($urandom);
      bitrev_en = (sent == 0) ? brev : 1'($urandom);
      fft_done  = inj && ($urandom_range(3) == 0);
      nb = beat_cyc.size();
      step();
      if (beat_cyc.size() > nb) begin
        ex_xr[sent] = s_xr; ex_xi[sent] = s_xi; sent++;
      end
    end
    check("beats_accepted", sent, n);
    s_valid = 1'b0; s_last = 1'b0; fft_done = 1'b0;
    guard = 0;
    while (fr_n == 0 && guard < 40) begin step(); guard++; end
    // Upstream keeps offering data while the frame is held; nothing may be taken.
    repeat (3) begin s_valid = 1'b1; s_xr = W'($urandom); step(); end
    s_valid = 1'b0;
    check("hold_s_ready", s_ready, 0);
    check("hold_busy", busy, 1);
    check("n_loads", wr_addr.size(), 16);
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      ea  = brev ? rev4(i) : i;
      exr = (i < n) ? ex_xr[i] : '0;
      exi = (i < n) ? ex_xi[i] : '0;
      check("wr_addr", wr_addr[i], ea);
      check("wr_xr", wr_xr[i], exr);
      check("wr_xi", wr_xi[i], exi);
    end
    bad_lat = 0;
    for (int i = 0; i < n && i < wr_cyc.size() && i < beat_cyc.size(); i++)
      if (wr_cyc[i] != beat_cyc[i]) bad_lat++;
    check("load_latency", bad_lat, 0);
    if (wr_cyc.size() == 16) begin
      bad_pad = 0; bad_busy = 0;
      for (int i = n; i < 16; i++) begin
        if (wr_cyc[i] - wr_cyc[n-1] != i - (n - 1)) bad_pad++;
        if (!wr_busy[i]) bad_busy++;
      end
      check("pad_timing", bad_pad, 0);
      check("pad_busy", bad_busy, 0);
      check("frame_ready_cycle", fr_cyc, wr_cyc[15] + 1);
      if (es_n == 1) check("err_short_cycle", es_cyc, wr_cyc[n-1]);
      if (el_n == 1) check("err_long_cycle", el_cyc, wr_cyc[15]);
    end
    check("frame_ready_count", fr_n, 1);
    check("err_short_count", es_n, (n < 16) ? 1 : 0);
    check("err_long_count", el_n, (n == 16 && !give_last) ? 1 : 0);
    check("hold_addr", addr_in, 15);
    exr = (n == 16) ? ex_xr[15] : '0;
    check("hold_xr", xr_in, exr);
  endtask

  task automatic release_frame();
    repeat ($urandom_range(2)) step();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("release_s_ready", s_ready, 1);
    check("release_busy", busy, 0);
  endtask

  // Partial frame cut short by a one-cycle reset: nothing of it may surface.
  task automatic abort_reset(input int nb, input bit give_last, input int extra);
    int sent, guard, b0;
    clear_obs();
    sent = 0; guard = 0;
    s_valid = 1'b1;
    while (sent < nb && guard < 100) begin
      guard++;
      s_xr = W'($urandom); s_xi = W'($urandom);
      s_last = give_last && (sent == nb - 1);
      bitrev_en = 1'($urandom);
      b0 = beat_cyc.size();
      step();
      if (beat_cyc.size() > b0) sent++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (extra) step();
    rst = 1'b1;
    step();
    check_reset("abort_rst");
    rst = 1'b0;
    clear_obs();
    repeat (4) step();
    check("abort_no_frame_ready", fr_n, 0);
    check("abort_no_load", wr_addr.size(), 0);
    check("abort_s_ready", s_ready, 1);
  endtask

  initial begin
    int n;
    bit gl;
    repeat (2) step();
    check_reset("init");
    rst = 1'b0;
    step();
    check("post_reset_s_ready", s_ready, 1);

    run_frame(16, 1'b1, 1'b0, 100, 1'b0); release_frame();   // natural order
    run_frame(16, 1'b1, 1'b1, 100, 1'b0); release_frame();   // bit-reversed
    run_frame(5,  1'b1, 1'b0, 100, 1'b0); release_frame();   // short, padded
    run_frame(16, 1'b0, 1'b0, 100, 1'b0); release_frame();   // long
    run_frame(16, 1'b1, 1'($urandom), 60, 1'b1); release_frame();  // gaps + stray fft_done
    run_frame(15, 1'b1, 1'b1, 100, 1'b0); release_frame();   // last-but-one
    run_frame(1,  1'b1, 1'b1, 80, 1'b1);  release_frame();   // single beat

    abort_reset(7, 1'b0, 0);
    run_frame(16, 1'b1, 1'b0, 100, 1'b0); release_frame();
    abort_reset(3, 1'b1, 2);                                  // reset in PAD
    run_frame(16, 1'b1, 1'b1, 100, 1'b0);
    rst = 1'b1; step(); check_reset("hold_rst"); rst = 1'b0;  // reset in HOLD
    run_frame(16, 1'b1, 1'b0, 90, 1'b0); release_frame();

    for (int f = 0; f < 8; f++) begin
      n  = $urandom_range(1, 16);
      gl = (n < 16) ? 1'b1 : 1'($urandom);
      run_frame(n, gl, 1'($urandom), $urandom_range(40, 100), 1'($urandom));
      release_frame();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter N, default 16, FFT frame length in samples; only 16 supported, address width fixed at 4.
REQ-002 Parameter WIDTH, default 16, signed sample width for real and imaginary parts.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  block accepts a sample this cycle; a beat transfers when s_valid && s_ready.
REQ-007 s_xr, s_xi  input  WIDTH each  signed real/imag sample.
REQ-008 s_last  input  1  marks final sample of a frame.
REQ-009 bitrev_en  input  1  1 = write addresses in bit-reversed order, 0 = natural order.
REQ-010 fft_done  input  1  one-cycle pulse from the FFT core; buffer may be overwritten.
REQ-011 load  output  1  write strobe to input_buffer.
REQ-012 addr_in  output  4  write address to input_buffer.
REQ-013 xr_in, xi_in  output  WIDTH each  write data to input_buffer.
REQ-014 frame_ready  output  1  one-cycle pulse: all N buffer locations written for the current frame.
REQ-015 busy  output  1  frame complete or padding; upstream is stalled.
REQ-016 err_short, err_long  output  1 each  one-cycle frame-length error pulses.

Function
REQ-017 FSM states FILL, PAD, HOLD; the state after reset is FILL.
REQ-018 s_ready SHALL be combinational: 1 iff state==FILL and rst==0.
REQ-019 Sample counter cnt (0..N-1) counts accepted beats in FILL and is cleared on entry to FILL.
REQ-020 bitrev_en is sampled on the beat with cnt==0 and held for the whole frame; mid-frame changes are ignored.
REQ-021 Address mapping: natural = cnt; bit-reversed = {cnt[0],cnt[1],cnt[2],cnt[3]}.
REQ-022 All outputs to input_buffer are registered: a beat accepted in cycle t gives load=1, addr_in, xr_in, xi_in in cycle t+1; otherwise load=0, and addr_in/xr_in/xi_in hold their last values.
REQ-023 Beat at cnt==N-1: FILL->HOLD regardless of s_last; if s_last==0, pulse err_long in cycle t+1.
REQ-024 Beat at cnt==k<N-1 with s_last==1: pulse err_short in cycle t+1 and go FILL->PAD.
REQ-025 PAD writes zeros (xr_in=xi_in=0, load=1), one per cycle, to the mapped addresses of indices k+1..N-1, then goes to HOLD.
REQ-026 frame_ready pulses for exactly one cycle, in the cycle after the last load of the frame (normal or padded).
REQ-027 busy=1 in PAD and HOLD, else 0.
REQ-028 HOLD->FILL on fft_done==1; s_ready rises in the following cycle.
REQ-029 fft_done in FILL or PAD is ignored, with no state effect.
REQ-030 A beat accepted with s_last==0 at cnt<N-1 has no side effect beyond the write.
REQ-031 Data passes through unmodified; there is no arithmetic or saturation.

Reset
REQ-032 While rst==1: state=FILL, cnt=0, s_ready=0, load=0, addr_in=0, xr_in=0, xi_in=0, frame_ready=0, busy=0, err_short=0, err_long=0.
REQ-033 Reset mid-frame, in PAD or in HOLD discards the partial frame; no frame_ready is issued; the next accepted beat is cnt=0.

Verification
REQ-034 bitrev_en=0; 16 back-to-back beats with xr=0..15, xi=0, s_last on the 16th -> 16 consecutive loads with addr_in=xr_in=0..15; frame_ready pulses 1 cycle after the 16th load; no errors; then s_ready=0 and busy=1.
REQ-035 bitrev_en=1; beats xr=0..15 -> addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with xr_in=0..15.
REQ-036 bitrev_en=0; 5 beats, s_last on the 5th -> err_short pulse; PAD writes 0 to addr 5..15 (11 cycles); frame_ready follows; busy=1 throughout PAD.
REQ-037 16 beats with s_last=0 -> err_long pulse with the 16th load; HOLD; fft_done pulse -> s_ready=1 next cycle; the next frame starts at addr 0.
REQ-038 s_valid toggled randomly with a fft_done pulse injected during FILL -> write order and data unchanged; fft_done ignored.
REQ-039 rst asserted for 1 cycle after 7 beats -> all outputs at reset values; a fresh 16-beat frame loads addr 0..15 with exactly one frame_ready.
